// File: rtl/motor_drive_ctrl_pkg.sv
// Shared definitions for the motor drive block: steering command codes,
// H-bridge direction encodings, wheel FSM states and the command decoder.
package motor_drive_ctrl_pkg;

    localparam logic [2:0] CMD_LEFT        = 3'b000;
    localparam logic [2:0] CMD_RIGHT       = 3'b001;
    localparam logic [2:0] CMD_STRAIGHT    = 3'b010;
    localparam logic [2:0] CMD_STOP        = 3'b011;
    localparam logic [2:0] CMD_SHARP_LEFT  = 3'b100;
    localparam logic [2:0] CMD_SHARP_RIGHT = 3'b101;

    localparam logic [1:0] IN_FWD   = 2'b10;
    localparam logic [1:0] IN_REV   = 2'b01;
    localparam logic [1:0] IN_COAST = 2'b00;

    typedef enum logic [1:0] {
        WHEEL_IDLE  = 2'd0,
        WHEEL_RUN   = 2'd1,
        WHEEL_DECEL = 2'd2,
        WHEEL_DEAD  = 2'd3
    } wheel_state_e;

    // Per-wheel intent derived from one steering command
    typedef struct packed {
        logic stop;
        logic left_rev;
        logic left_fast;
        logic right_rev;
        logic right_fast;
    } wheel_cmd_t;

    // Unknown codes (110, 111) fall into the stop branch
    function automatic wheel_cmd_t decode_cmd(input logic [2:0] cmd);
        wheel_cmd_t c;
        c = '{stop: 1'b1, left_rev: 1'b0, left_fast: 1'b0, right_rev: 1'b0, right_fast: 1'b0};
        case (cmd)
            CMD_STRAIGHT:    c = '{stop: 1'b0, left_rev: 1'b0, left_fast: 1'b1, right_rev: 1'b0, right_fast: 1'b1};
            CMD_LEFT:        c = '{stop: 1'b0, left_rev: 1'b0, left_fast: 1'b0, right_rev: 1'b0, right_fast: 1'b1};
            CMD_RIGHT:       c = '{stop: 1'b0, left_rev: 1'b0, left_fast: 1'b1, right_rev: 1'b0, right_fast: 1'b0};
            CMD_SHARP_LEFT:  c = '{stop: 1'b0, left_rev: 1'b1, left_fast: 1'b0, right_rev: 1'b0, right_fast: 1'b1};
            CMD_SHARP_RIGHT: c = '{stop: 1'b0, left_rev: 1'b0, left_fast: 1'b1, right_rev: 1'b1, right_fast: 1'b0};
            default:         c = '{stop: 1'b1, left_rev: 1'b0, left_fast: 1'b0, right_rev: 1'b0, right_fast: 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/motor_drive_ctrl_wheel.sv
// One wheel: direction FSM with slew-limited duty, dead-time before a
// reversal, and the registered PWM comparator against the shared counter.
module motor_wheel_ctrl
    import motor_drive_ctrl_pkg::*;
#(
    parameter int PWM_PERIOD   = 100,
    parameter int RAMP_STEP    = 20,
    parameter int DEAD_PERIODS = 2,
    localparam int DUTY_W      = $clog2(PWM_PERIOD + 1),
    localparam int CNT_W       = $clog2(PWM_PERIOD)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              stop,
    input  logic [CNT_W-1:0]  cnt,
    input  logic              tgt_rev,
    input  logic [DUTY_W-1:0] tgt_duty,
    output logic              pwm,
    output logic [1:0]        in,
    output logic [DUTY_W-1:0] duty
);

    localparam int DCNT_W = $clog2(DEAD_PERIODS + 1);
    localparam logic [DUTY_W-1:0] DUTY_ZERO = {DUTY_W{1'b0}};
    localparam logic [DUTY_W-1:0] STEP_D    = DUTY_W'(RAMP_STEP);
    localparam logic [DCNT_W-1:0] DCNT_ZERO = {DCNT_W{1'b0}};
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEAD_PERIODS - 1);

    wheel_state_e      state_r, state_next_s;
    logic              dir_r, dir_next_s;
    logic [DUTY_W-1:0] duty_r, duty_next_s;
    logic [DCNT_W-1:0] dcnt_r, dcnt_next_s;
    logic [1:0]        in_r, in_next_s;
    logic              pwm_r;

    // Move cur toward tgt by at most one step, landing exactly on tgt
    function automatic logic [DUTY_W-1:0] ramp_toward(input logic [DUTY_W-1:0] cur,
                                                      input logic [DUTY_W-1:0] tgt);
        logic [DUTY_W-1:0] r;
        if (cur < tgt) begin
            r = ((tgt - cur) > STEP_D) ? (cur + STEP_D) : tgt;
        end else if (cur > tgt) begin
            r = ((cur - tgt) > STEP_D) ? (cur - STEP_D) : tgt;
        end else begin
            r = cur;
        end
        return r;
    endfunction

    // Decelerate by one step, never below zero
    function automatic logic [DUTY_W-1:0] ramp_down(input logic [DUTY_W-1:0] cur);
        return (cur > STEP_D) ? (cur - STEP_D) : DUTY_ZERO;
    endfunction

    // Next-state, duty and direction decisions; everything advances only on tick
    always_comb begin
        state_next_s = state_r;
        dir_next_s   = dir_r;
        duty_next_s  = duty_r;
        dcnt_next_s  = dcnt_r;
        if (tick) begin
            case (state_r)
                WHEEL_IDLE: begin
                    if (tgt_duty != DUTY_ZERO) begin
                        state_next_s = WHEEL_RUN;
                        dir_next_s   = tgt_rev;
                        duty_next_s  = ramp_toward(duty_r, tgt_duty);
                    end else begin
                        duty_next_s  = DUTY_ZERO;
                    end
                end
                WHEEL_RUN, WHEEL_DECEL: begin
                    if (tgt_rev == dir_r) begin
                        state_next_s = WHEEL_RUN;
                        duty_next_s  = ramp_toward(duty_r, tgt_duty);
                    end else begin
                        // Reversal request: braking starts on this same tick
                        duty_next_s = ramp_down(duty_r);
                        if (ramp_down(duty_r) == DUTY_ZERO) begin
                            state_next_s = WHEEL_DEAD;
                            dcnt_next_s  = DCNT_ZERO;
                        end else begin
                            state_next_s = WHEEL_DECEL;
                        end
                    end
                end
                WHEEL_DEAD: begin
                    if (dcnt_r == DCNT_LAST) begin
                        state_next_s = WHEEL_RUN;
                        dir_next_s   = tgt_rev;
                        duty_next_s  = ramp_toward(duty_r, tgt_duty);
                    end else begin
                        dcnt_next_s  = dcnt_r + DCNT_W'(1);
                    end
                end
                default: begin
                    state_next_s = WHEEL_IDLE;
                    duty_next_s  = DUTY_ZERO;
                    dcnt_next_s  = DCNT_ZERO;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
        // The bridge is driven only while the wheel is powered in a direction
        case (state_next_s)
            WHEEL_RUN, WHEEL_DECEL: in_next_s = dir_next_s ? IN_REV : IN_FWD;
            default:                in_next_s = IN_COAST;
        endcase
    end

    // State/output registers; stop forces a safe coast on any cycle
    always_ff @(posedge clk) begin
        if (reset || stop) begin
            state_r <= WHEEL_IDLE;
            dir_r   <= 1'b0;
            duty_r  <= DUTY_ZERO;
            dcnt_r  <= DCNT_ZERO;
            in_r    <= IN_COAST;
            pwm_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            dir_r   <= dir_next_s;
            duty_r  <= duty_next_s;
            dcnt_r  <= dcnt_next_s;
            in_r    <= in_next_s;
            pwm_r   <= (DUTY_W'(cnt) < duty_r);
        end
    end

    assign pwm  = pwm_r;
    assign in   = in_r;
    assign duty = duty_r;

endmodule

// File: rtl/motor_drive_ctrl.sv
// Motor drive top: shared PWM counter and tick, steering decode, and one
// wheel controller per motor.
module motor_drive_ctrl
    import motor_drive_ctrl_pkg::*;
#(
    parameter int PWM_PERIOD   = 100,
    parameter int DUTY_FAST    = 80,
    parameter int DUTY_SLOW    = 40,
    parameter int RAMP_STEP    = 20,
    parameter int DEAD_PERIODS = 2,
    localparam int DUTY_W      = $clog2(PWM_PERIOD + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        state,
    output logic              left_pwm,
    output logic [1:0]        left_in,
    output logic              right_pwm,
    output logic [1:0]        right_in,
    output logic [DUTY_W-1:0] left_duty,
    output logic [DUTY_W-1:0] right_duty
);

    localparam int CNT_W = $clog2(PWM_PERIOD);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PWM_PERIOD - 1);
    localparam logic [DUTY_W-1:0] FAST_D    = DUTY_W'(DUTY_FAST);
    localparam logic [DUTY_W-1:0] SLOW_D    = DUTY_W'(DUTY_SLOW);
    localparam logic [DUTY_W-1:0] DUTY_ZERO = {DUTY_W{1'b0}};

    logic [CNT_W-1:0]  cnt_r;
    logic              tick_s;
    wheel_cmd_t        cmd_s;
    logic [DUTY_W-1:0] left_tgt_s, right_tgt_s;

    assign tick_s = (cnt_r == CNT_LAST);

    // Free-running PWM period counter
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (tick_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Translate the steering code into per-wheel direction and target duty
    always_comb begin
        cmd_s       = decode_cmd(state);
        left_tgt_s  = cmd_s.stop ? DUTY_ZERO : (cmd_s.left_fast  ? FAST_D : SLOW_D);
        right_tgt_s = cmd_s.stop ? DUTY_ZERO : (cmd_s.right_fast ? FAST_D : SLOW_D);
    end

    motor_wheel_ctrl #(
        .PWM_PERIOD   (PWM_PERIOD),
        .RAMP_STEP    (RAMP_STEP),
        .DEAD_PERIODS (DEAD_PERIODS)
    ) u_left (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick_s),
        .stop     (cmd_s.stop),
        .cnt      (cnt_r),
        .tgt_rev  (cmd_s.left_rev),
        .tgt_duty (left_tgt_s),
        .pwm      (left_pwm),
        .in       (left_in),
        .duty     (left_duty)
    );

    motor_wheel_ctrl #(
        .PWM_PERIOD   (PWM_PERIOD),
        .RAMP_STEP    (RAMP_STEP),
        .DEAD_PERIODS (DEAD_PERIODS)
    ) u_right (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick_s),
        .stop     (cmd_s.stop),
        .cnt      (cnt_r),
        .tgt_rev  (cmd_s.right_rev),
        .tgt_duty (right_tgt_s),
        .pwm      (right_pwm),
        .in       (right_in),
        .duty     (right_duty)
    );

endmodule
